// File: rtl/apb_pkg.sv
// Shared APB types and address constants for the register completer and its master.
// No logic; the FSM state encoding and request bundle live here so both sides agree.
package apb_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hDEAD_CAF0;
  localparam logic [31:0] DEAD_CAFE_ADDR    = 32'hDEAD_CAFE;
  localparam logic [31:0] DEFAULT_ID_VALUE  = 32'hA9B0_0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
  } apb_req_t;

endpackage

// File: rtl/apb_reg_bank.sv
// Register array with index 0 hard-wired to a read-only ID; combinational read port.
// Writes land on the clock edge when wr_en is high; no backpressure.
module apb_reg_bank
  import apb_pkg::*;
#(
  parameter int          NUM_REGS = 4,
  parameter logic [31:0] ID_VALUE = DEFAULT_ID_VALUE,
  localparam int         IDX_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data
);

  logic [31:0] regs [1:NUM_REGS-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wr_idx == i[IDX_W-1:0]) regs[i] <= wr_data;
      end
    end
  end

  always_comb begin
    rd_data = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rd_idx == i[IDX_W-1:0]) rd_data = regs[i];
    end
  end

endmodule

// File: rtl/apb_reg_slave.sv
// APB completer for a small register window; pready_o lands WAIT_CYCLES+1 cycles after setup.
// psel_i dropping while waiting aborts the transfer without a commit.
module apb_reg_slave
  import apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          NUM_REGS    = 4,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = DEFAULT_ID_VALUE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic [31:0] paddr_i,
  input  logic        pwrite_i,
  input  logic [31:0] pwdata_i,
  output logic        pready_o,
  output logic [31:0] prdata_o,
  output logic        pslverr_o
);

  localparam int          IDX_W    = $clog2(NUM_REGS);
  localparam logic [31:0] WIN_MASK = ~(32'(NUM_REGS * 4) - 32'd1);

  apb_req_t         req;
  state_t           state, next_state;
  logic             hit, dec_err, setup, access;
  logic [IDX_W-1:0] dec_idx, idx_q, rd_idx;
  logic             err_q, write_q, cur_err, cur_write, resp_nxt, wr_en;
  logic [3:0]       cnt;
  logic [31:0]      rd_data, prdata_d;

  assign req     = '{addr: paddr_i, write: pwrite_i, wdata: pwdata_i};
  assign hit     = (req.addr & WIN_MASK) == BASE_ADDR;
  assign dec_idx = req.addr[2 +: IDX_W];
  assign dec_err = !hit || (req.write && dec_idx == '0);
  assign setup   = psel_i && !penable_i;
  assign access  = psel_i && penable_i;

  // Transfer attributes are frozen at setup so access-phase address changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      write_q <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && setup) begin
        idx_q   <= dec_idx;
        err_q   <= dec_err;
        write_q <= req.write;
        cnt     <= 4'(WAIT_CYCLES);
      end else if (state == WAIT && access) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (setup) next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: begin
        if (!psel_i)                         next_state = IDLE;
        else if (penable_i && cnt == 4'd1)   next_state = RESP;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Zero-wait builds go IDLE->RESP directly, so the live decode feeds the response.
  always_comb begin
    cur_err   = err_q;
    cur_write = write_q;
    rd_idx    = idx_q;
    if (state == IDLE) begin
      cur_err   = dec_err;
      cur_write = req.write;
      rd_idx    = dec_idx;
    end
    resp_nxt = (next_state == RESP);
    wr_en    = (state == RESP) && write_q && !err_q && access;
  end

  assign prdata_d = (resp_nxt && !cur_err && !cur_write) ? rd_data : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pready_o  <= 1'b0;
      prdata_o  <= '0;
      pslverr_o <= 1'b0;
    end else begin
      pready_o  <= resp_nxt;
      pslverr_o <= resp_nxt && cur_err;
      prdata_o  <= prdata_d;
    end
  end

  apb_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_idx  (idx_q),
    .wr_data (req.wdata)
  );

endmodule
